// File: rtl/router_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// router_fsm_ctrl
// Packet-reception controller for the 1x3 router. Walks each packet through
// header decode, payload load, full-FIFO stall, parity load/check and the
// wait for a busy destination FIFO. Drives the register block strobes
// (lfd/ld/laf/rst_int) and the synchronizer controls (detect_add,
// write_enb_reg). All outputs are Moore outputs of the current state; they are
// registered from the next state so they line up with the state register.
// -----------------------------------------------------------------------------
module router_fsm_ctrl #(
  parameter int ADDR_W    = 2,
  parameter int NUM_PORTS = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  typedef struct packed {
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic write_enb_reg;
    logic rst_int_reg;
    logic busy;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{detect_add: 1'b1, default: 1'b0};

  state_t            state;
  state_t            state_nxt;
  ctrl_t             ctrl;
  logic [ADDR_W-1:0] addr_lat;

  logic [NUM_PORTS-1:0] empty_vec;
  logic [NUM_PORTS-1:0] soft_vec;
  logic                 din_ok;
  logic                 din_empty;
  logic                 lat_empty;
  logic                 soft_hit;

  assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};

  // Address 3 has no FIFO behind it; such headers are ignored.
  assign din_ok    = (data_in < ADDR_W'(NUM_PORTS));
  assign din_empty = din_ok && empty_vec[data_in];
  assign lat_empty = (addr_lat < ADDR_W'(NUM_PORTS)) && empty_vec[addr_lat];
  assign soft_hit  = (addr_lat < ADDR_W'(NUM_PORTS)) && soft_vec[addr_lat];

  // Moore output decode: one table row per state, strobes mutually exclusive.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      DECODE_ADDRESS:     c.detect_add = 1'b1;
      LOAD_FIRST_DATA:    begin c.lfd_state = 1'b1; c.busy = 1'b1; end
      LOAD_DATA:          begin c.ld_state = 1'b1; c.write_enb_reg = 1'b1; end
      FIFO_FULL_STATE:    begin c.full_state = 1'b1; c.busy = 1'b1; end
      LOAD_AFTER_FULL:    begin c.laf_state = 1'b1; c.write_enb_reg = 1'b1; c.busy = 1'b1; end
      LOAD_PARITY:        begin c.write_enb_reg = 1'b1; c.busy = 1'b1; end
      CHECK_PARITY_ERROR: begin c.rst_int_reg = 1'b1; c.busy = 1'b1; end
      WAIT_TILL_EMPTY:    c.busy = 1'b1;
      default:            c = CTRL_RESET;
    endcase
    return c;
  endfunction

  // Next-state selection; soft reset of the latched port overrides everything.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    if (soft_hit) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid && din_ok)
            state_nxt = din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) state_nxt = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_nxt = DECODE_ADDRESS;
          else if (low_pkt_valid) state_nxt = LOAD_PARITY;
          else                    state_nxt = LOAD_DATA;
        end
        LOAD_PARITY:        state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          if (lat_empty) state_nxt = LOAD_FIRST_DATA;
        end
        default: state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  // State register with outputs registered alongside it from the next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= DECODE_ADDRESS;
      ctrl  <= CTRL_RESET;
    end else begin
      state <= state_nxt;
      ctrl  <= decode_ctrl(state_nxt);
    end
  end

  // Latch the destination of an accepted header for the wait and soft-reset paths.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_lat <= '0;
    end else if (state == DECODE_ADDRESS && pkt_valid && din_ok) begin
      addr_lat <= data_in;
    end
  end

  assign detect_add    = ctrl.detect_add;
  assign lfd_state     = ctrl.lfd_state;
  assign ld_state      = ctrl.ld_state;
  assign laf_state     = ctrl.laf_state;
  assign full_state    = ctrl.full_state;
  assign write_enb_reg = ctrl.write_enb_reg;
  assign rst_int_reg   = ctrl.rst_int_reg;
  assign busy          = ctrl.busy;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_router_fsm_ctrl
// Directed bench for the router reception controller. Each task applies a
// table of per-cycle inputs and compares the eight output strobes after each
// rising edge against hand-derived per-state output patterns.
// -----------------------------------------------------------------------------
module tb_router_fsm_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  int vectors     = 0;
  int miscompares = 0;

  // Output pattern {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  localparam logic [7:0] O_DEC  = 8'b1000_0000;
  localparam logic [7:0] O_LFD  = 8'b0100_0001;
  localparam logic [7:0] O_LD   = 8'b0010_0100;
  localparam logic [7:0] O_FULL = 8'b0000_1001;
  localparam logic [7:0] O_LAF  = 8'b0001_0101;
  localparam logic [7:0] O_LP   = 8'b0000_0101;
  localparam logic [7:0] O_CHK  = 8'b0000_0011;
  localparam logic [7:0] O_WAIT = 8'b0000_0001;

  logic [7:0] outs;
  assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                 write_enb_reg, rst_int_reg, busy};

  // One cycle of stimulus plus the output pattern expected after the edge.
  typedef struct packed {
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic       lpv;
    logic       pd;
    logic [2:0] empty;
    logic [2:0] sr;
    logic [7:0] exp;
  } vec_t;

  function automatic vec_t v(input logic pv, input logic [1:0] din, input logic full,
                             input logic lpv, input logic pd, input logic [2:0] empty,
                             input logic [2:0] sr, input logic [7:0] exp);
    vec_t r;
    r = '{pv: pv, din: din, full: full, lpv: lpv, pd: pd, empty: empty, sr: sr, exp: exp};
    return r;
  endfunction

  router_fsm_ctrl #(.ADDR_W(2), .NUM_PORTS(3)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic apply(input vec_t x);
    pkt_valid     = x.pv;
    data_in       = x.din;
    fifo_full     = x.full;
    low_pkt_valid = x.lpv;
    parity_done   = x.pd;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = x.empty;
    {soft_reset_2, soft_reset_1, soft_reset_0} = x.sr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    low_pkt_valid = 1'b0; parity_done = 1'b0;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = 3'b111;
    {soft_reset_2, soft_reset_1, soft_reset_0} = 3'b000;
  endtask

  task automatic test_reset();
    vec_t t [3];
    idle_inputs();
    resetn = 1'b0;
    #12;
    vectors++;
    if (outs !== O_DEC) begin
      miscompares++;
      $display("FAIL reset_asserted: got %b want %b", outs, O_DEC);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) t[i] = v(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000, O_DEC);
    for (int i = 0; i < 3; i++) begin
      apply(t[i]);
      vectors++;
      if (outs !== t[i].exp) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, outs, t[i].exp);
      end
    end
  endtask

  task automatic test_good_packet();
    vec_t t [7];
    int   rst_int_cycles = 0;
    t = '{v(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LFD),
          v(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LD),
          v(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LD),
          v(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LD),
          v(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LP),
          v(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_CHK),
          v(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_DEC)};
    for (int i = 0; i < 7; i++) begin
      apply(t[i]);
      if (rst_int_reg === 1'b1) rst_int_cycles++;
      vectors++;
      if (outs !== t[i].exp) begin
        miscompares++;
        $display("FAIL good_packet[%0d]: got %b want %b", i, outs, t[i].exp);
      end
    end
    vectors++;
    if (rst_int_cycles !== 1) begin
      miscompares++;
      $display("FAIL good_packet_rst_int_cycles: got %0d want 1", rst_int_cycles);
    end
  endtask

  task automatic test_wait_till_empty();
    vec_t t [10];
    t = '{v(1, 2'd2, 0, 0, 0, 3'b011, 3'b000, O_WAIT),
          v(1, 2'd2, 0, 0, 0, 3'b011, 3'b000, O_WAIT),
          v(1, 2'd2, 0, 0, 0, 3'b011, 3'b000, O_WAIT),
          v(1, 2'd2, 0, 0, 0, 3'b011, 3'b000, O_WAIT),
          v(1, 2'd2, 0, 0, 0, 3'b011, 3'b000, O_WAIT),
          v(1, 2'd2, 0, 0, 0, 3'b111, 3'b000, O_LFD),
          v(1, 2'd2, 0, 0, 0, 3'b111, 3'b000, O_LD),
          v(0, 2'd2, 0, 0, 0, 3'b111, 3'b000, O_LP),
          v(0, 2'd2, 0, 0, 0, 3'b111, 3'b000, O_CHK),
          v(0, 2'd2, 0, 0, 0, 3'b111, 3'b000, O_DEC)};
    for (int i = 0; i < 10; i++) begin
      apply(t[i]);
      vectors++;
      if (outs !== t[i].exp) begin
        miscompares++;
        $display("FAIL wait_till_empty[%0d]: got %b want %b", i, outs, t[i].exp);
      end
    end
  endtask

  // Full stall; fifo_full and !pkt_valid together in LOAD_DATA must pick the stall.
  task automatic test_fifo_full();
    vec_t t [10];
    t = '{v(1, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LFD),
          v(1, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LD),
          v(0, 2'd0, 1, 0, 0, 3'b111, 3'b000, O_FULL),
          v(0, 2'd0, 1, 0, 0, 3'b111, 3'b000, O_FULL),
          v(0, 2'd0, 1, 0, 0, 3'b111, 3'b000, O_FULL),
          v(0, 2'd0, 1, 0, 0, 3'b111, 3'b000, O_FULL),
          v(0, 2'd0, 0, 1, 0, 3'b111, 3'b000, O_LAF),
          v(0, 2'd0, 0, 1, 0, 3'b111, 3'b000, O_LP),
          v(0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_CHK),
          v(0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_DEC)};
    for (int i = 0; i < 10; i++) begin
      apply(t[i]);
      vectors++;
      if (outs !== t[i].exp) begin
        miscompares++;
        $display("FAIL fifo_full[%0d]: got %b want %b", i, outs, t[i].exp);
      end
    end
  endtask

  // LAF back to LD, CHECK into FULL, and LAF exit on parity_done.
  task automatic test_laf_paths();
    vec_t t [10];
    t = '{v(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LFD),
          v(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LD),
          v(1, 2'd1, 1, 0, 0, 3'b111, 3'b000, O_FULL),
          v(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LAF),
          v(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LD),
          v(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LP),
          v(0, 2'd1, 1, 0, 0, 3'b111, 3'b000, O_CHK),
          v(0, 2'd1, 1, 0, 0, 3'b111, 3'b000, O_FULL),
          v(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LAF),
          v(0, 2'd1, 0, 0, 1, 3'b111, 3'b000, O_DEC)};
    for (int i = 0; i < 10; i++) begin
      apply(t[i]);
      vectors++;
      if (outs !== t[i].exp) begin
        miscompares++;
        $display("FAIL laf_paths[%0d]: got %b want %b", i, outs, t[i].exp);
      end
    end
  endtask

  task automatic test_soft_reset();
    vec_t t [5];
    t = '{v(1, 2'd0, 0, 0, 0, 3'b110, 3'b000, O_WAIT),
          v(1, 2'd0, 0, 0, 0, 3'b110, 3'b010, O_WAIT),
          v(1, 2'd0, 0, 0, 0, 3'b110, 3'b110, O_WAIT),
          v(0, 2'd0, 0, 0, 0, 3'b110, 3'b001, O_DEC),
          v(0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_DEC)};
    for (int i = 0; i < 5; i++) begin
      apply(t[i]);
      vectors++;
      if (outs !== t[i].exp) begin
        miscompares++;
        $display("FAIL soft_reset[%0d]: got %b want %b", i, outs, t[i].exp);
      end
    end
  endtask

  // Header to address 3 is ignored; the latched address stays at 0 from the prior packet.
  task automatic test_invalid_addr();
    vec_t t [3];
    for (int i = 0; i < 3; i++) t[i] = v(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000, O_DEC);
    for (int i = 0; i < 3; i++) begin
      apply(t[i]);
      vectors++;
      if (outs !== t[i].exp) begin
        miscompares++;
        $display("FAIL invalid_addr[%0d]: got %b want %b", i, outs, t[i].exp);
      end
    end
    vectors++;
    if (dut.addr_lat !== 2'd0) begin
      miscompares++;
      $display("FAIL invalid_addr_lat: got %0d want 0", dut.addr_lat);
    end
  endtask

  task automatic test_reset_mid_packet();
    vec_t t [3];
    t = '{v(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LFD),
          v(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LD),
          v(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_DEC)};
    for (int i = 0; i < 2; i++) begin
      apply(t[i]);
      vectors++;
      if (outs !== t[i].exp) begin
        miscompares++;
        $display("FAIL reset_mid_packet[%0d]: got %b want %b", i, outs, t[i].exp);
      end
    end
    #2;
    resetn = 1'b0;
    #1;
    vectors++;
    if (outs !== O_DEC) begin
      miscompares++;
      $display("FAIL reset_mid_packet_async: got %b want %b", outs, O_DEC);
    end
    @(negedge clk);
    resetn = 1'b1;
    apply(t[2]);
    vectors++;
    if (outs !== t[2].exp) begin
      miscompares++;
      $display("FAIL reset_mid_packet_after: got %b want %b", outs, t[2].exp);
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_wait_till_empty();
    test_fifo_full();
    test_laf_paths();
    test_soft_reset();
    test_invalid_addr();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
